// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus pacer feeding the simple UART transmitter.
// The UART has no busy/ack, so each byte is followed by a fixed wait of one
// frame plus guard bits before the next tx_ready pulse is issued.
// Optional feature: define UART_TX_FEEDER_FLUSH_EN to add a synchronous
// 'flush' input that empties the FIFO without disturbing a byte in flight.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a byte; pops the head byte and raises tx_ready
// PULSE | tx_ready high for this one cycle; pace counter cleared
// WAIT  | pacing one frame plus guard bits before returning to IDLE

module uart_tx_feeder #(
  parameter int CLOCK_RATE      = 32000000,
  parameter int BAUD_RATE       = 9600,
  parameter int GUARD_BITS      = 1,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PACE_BITS       = 20
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef UART_TX_FEEDER_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic [7:0]                 wr_data,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       empty,
  output logic [FIFO_DEPTH_LOG2:0]   level,
  output logic                       overflow,
  output logic                       busy,
  output logic [7:0]                 tx_send,
  output logic                       tx_ready
);

  localparam int DEPTH      = 1 << FIFO_DEPTH_LOG2;
  localparam int FRAME_CLKS = (CLOCK_RATE / BAUD_RATE) * (10 + GUARD_BITS);

  localparam logic [PACE_BITS-1:0]       PACE_LAST = PACE_BITS'(FRAME_CLKS - 1);
  localparam logic [PACE_BITS-1:0]       PACE_ONE  = PACE_BITS'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE   = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL  = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  logic                       full_q, full_d;
  logic                       empty_q, empty_d;
  logic                       overflow_q, overflow_d;
  state_t                     state_q, state_d;
  logic [PACE_BITS-1:0]       pace_q, pace_d;
  logic [7:0]                 tx_send_q, tx_send_d;
  logic                       tx_ready_q, tx_ready_d;
  logic                       push;
  logic                       pop;

  // Pacing FSM: pops the head byte, strobes tx_ready, then waits out the frame.
  always_comb begin
    state_d    = state_q;
    pace_d     = pace_q;
    tx_send_d  = tx_send_q;
    tx_ready_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          tx_send_d  = mem_q[rd_ptr_q];
          tx_ready_d = 1'b1;
          pop        = 1'b1;
          state_d    = ST_PULSE;
        end
      end
      ST_PULSE: begin
        pace_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        pace_d = pace_q + PACE_ONE;
        if (pace_q == PACE_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: a full FIFO drops the write even if a pop frees a slot this edge.
  always_comb begin
    push       = wr_en && !full_q;
    overflow_d = wr_en && full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
`ifdef UART_TX_FEEDER_FLUSH_EN
    if (flush) begin
      push       = 1'b0;
      overflow_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
`endif
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // Byte storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // State, pointers and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pace_q     <= '0;
      tx_send_q  <= '0;
      tx_ready_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pace_q     <= pace_d;
      tx_send_q  <= tx_send_d;
      tx_ready_q <= tx_ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == ST_PULSE) || (state_q == ST_WAIT);
  assign tx_send  = tx_send_q;
  assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with FRAME_CLKS=176 and a 4-byte FIFO.
// Expected values are hand-derived from the frame timing: pulses sit
// FRAME_CLKS+2 = 178 clocks apart and busy spans FRAME_CLKS+1 = 177 cycles.

module tb_uart_tx_feeder;

  localparam int LOG2 = 2;

  logic          clk;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [LOG2:0] level;
  logic          overflow;
  logic          busy;
  logic [7:0]    tx_send;
  logic          tx_ready;
`ifdef UART_TX_FEEDER_FLUSH_EN
  logic          flush;
`endif

  uart_tx_feeder #(
    .CLOCK_RATE     (1600000),
    .BAUD_RATE      (100000),
    .GUARD_BITS     (1),
    .FIFO_DEPTH_LOG2(LOG2),
    .PACE_BITS      (20)
  ) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef UART_TX_FEEDER_FLUSH_EN
    .flush   (flush),
`endif
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .overflow(overflow),
    .busy    (busy),
    .tx_send (tx_send),
    .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         pulse_cyc[$];
  logic [7:0] pulse_byte[$];
  int         busy_cyc;
  int         consec_err;
  int         send_change;
  int         ovf_cnt;
  int         ovf_cyc;
  int         full_first;
  int         full_last;
  int         max_level;
  logic       prev_ready;
  logic [7:0] prev_send;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    pulse_cyc.delete();
    pulse_byte.delete();
    busy_cyc    = 0;
    consec_err  = 0;
    send_change = 0;
    ovf_cnt     = 0;
    ovf_cyc     = -1;
    full_first  = -1;
    full_last   = -1;
    max_level   = 0;
    prev_ready  = tx_ready;
    prev_send   = tx_send;
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (tx_ready === 1'b1) begin
        if (prev_ready === 1'b1) consec_err++;
        pulse_cyc.push_back(cyc);
        pulse_byte.push_back(tx_send);
      end else if (tx_send !== prev_send) begin
        send_change++;
      end
      prev_ready = tx_ready;
      prev_send  = tx_send;
      if (busy === 1'b1) busy_cyc++;
      if (overflow === 1'b1) begin
        ovf_cnt++;
        if (ovf_cyc < 0) ovf_cyc = cyc;
      end
      if (full === 1'b1) begin
        if (full_first < 0) full_first = cyc;
        full_last = cyc;
      end
      if (int'(level) > max_level) max_level = int'(level);
    end
  endtask

  task automatic chk_pulse(input int idx, input logic [7:0] exp_byte, input int exp_cyc);
    chk($sformatf("pulse%0d_present", idx), 32'(idx < pulse_cyc.size()), 32'd1);
    if (idx < pulse_cyc.size()) begin
      chk($sformatf("pulse%0d_byte", idx), 32'(pulse_byte[idx]), 32'(exp_byte));
      chk($sformatf("pulse%0d_cycle", idx), pulse_cyc[idx], exp_cyc);
    end
  endtask

  int e0;

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
`ifdef UART_TX_FEEDER_FLUSH_EN
    flush   = 1'b0;
`endif
    run(3);
    rst = 1'b0;
    run(10);

    // Reset state after 10 idle clocks.
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tx_send",  32'(tx_send),  32'h00);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Single byte 0xA5.
    clear_stats();
    wr_en = 1'b1; wr_data = 8'hA5;
    run(1);
    e0 = cyc;
    wr_en = 1'b0;
    chk("a5_empty_e0", 32'(empty), 32'd0);
    chk("a5_level_e0", 32'(level), 32'd1);
    chk("a5_ready_e0", 32'(tx_ready), 32'd0);
    run(1);
    chk("a5_ready_e1", 32'(tx_ready), 32'd1);
    chk("a5_send_e1",  32'(tx_send),  32'hA5);
    chk("a5_level_e1", 32'(level),    32'd0);
    chk("a5_busy_e1",  32'(busy),     32'd1);
    run(1);
    chk("a5_ready_e2", 32'(tx_ready), 32'd0);
    chk("a5_send_e2",  32'(tx_send),  32'hA5);
    run(250);
    chk("a5_npulses", pulse_cyc.size(), 1);
    chk_pulse(0, 8'hA5, e0 + 1);
    chk("a5_busy_cycles", busy_cyc, 177);
    chk("a5_busy_end", 32'(busy), 32'd0);
    chk("a5_send_stable", send_change, 0);

    // Three bytes on consecutive clocks.
    clear_stats();
    wr_en = 1'b1; wr_data = 8'h11;
    run(1);
    e0 = cyc;
    wr_data = 8'h22; run(1);
    wr_data = 8'h33; run(1);
    wr_en = 1'b0;
    run(600);
    chk("three_npulses", pulse_cyc.size(), 3);
    chk_pulse(0, 8'h11, e0 + 1);
    chk_pulse(1, 8'h22, e0 + 1 + 178);
    chk_pulse(2, 8'h33, e0 + 1 + 356);
    chk("three_max_level", max_level, 2);
    chk("three_consec", consec_err, 0);
    chk("three_busy_cycles", busy_cyc, 3 * 177);
    chk("three_empty_end", 32'(empty), 32'd1);

    // Six bytes into a 4-deep FIFO: 0x06 is dropped.
    clear_stats();
    wr_en = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      wr_data = 8'(b);
      run(1);
      if (b == 1) e0 = cyc;
    end
    wr_en = 1'b0;
    run(950);
    chk("six_full_first", full_first, e0 + 4);
    chk("six_full_last",  full_last,  e0 + 178);
    chk("six_ovf_count",  ovf_cnt, 1);
    chk("six_ovf_cycle",  ovf_cyc, e0 + 5);
    chk("six_npulses", pulse_cyc.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk_pulse(k, 8'(k + 1), e0 + 1 + 178 * k);
    end
    chk("six_consec", consec_err, 0);
    chk("six_level_end", 32'(level), 32'd0);

    // Reset during WAIT of the second of three queued bytes.
    clear_stats();
    wr_en = 1'b1;
    wr_data = 8'hC1; run(1);
    e0 = cyc;
    wr_data = 8'hC2; run(1);
    wr_data = 8'hC3; run(1);
    wr_en = 1'b0;
    run(178 + 50);
    chk("rstmid_pre_send",  32'(tx_send), 32'hC2);
    chk("rstmid_pre_level", 32'(level),   32'd1);
    chk("rstmid_pre_busy",  32'(busy),    32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_send",     32'(tx_send),  32'h00);
    chk("rstmid_ready",    32'(tx_ready), 32'd0);
    chk("rstmid_busy",     32'(busy),     32'd0);
    chk("rstmid_empty",    32'(empty),    32'd1);
    chk("rstmid_level",    32'(level),    32'd0);
    chk("rstmid_full",     32'(full),     32'd0);
    chk("rstmid_overflow", 32'(overflow), 32'd0);
    run(2);
    rst = 1'b0;
    clear_stats();
    run(600);
    chk("rstmid_no_pulse", pulse_cyc.size(), 0);
    chk("rstmid_idle_busy", busy_cyc, 0);

`ifdef UART_TX_FEEDER_FLUSH_EN
    // Flush during WAIT of the first of four queued bytes.
    clear_stats();
    wr_en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wr_data = 8'(8'hD1 + b);
      run(1);
      if (b == 0) e0 = cyc;
    end
    wr_en = 1'b0;
    run(40);
    chk("flush_pre_level", 32'(level), 32'd3);
    flush = 1'b1;
    run(1);
    flush = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_busy_kept", 32'(busy), 32'd1);
    run(400);
    chk("flush_npulses", pulse_cyc.size(), 1);
    chk_pulse(0, 8'hD1, e0 + 1);
    chk("flush_busy_cycles", busy_cyc, 177);
    chk("flush_busy_end", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
